pe_out_requant: RTL and testbench
=================================

// Module: pe_out_requant
// PURPOSE
//  Output stage directly downstream of the Winograd PE core. Captures one result beat
//  (pooled or unpooled, X_PE lanes of OUT_BIT) per in_valid, requantizes each value to
//  DATA_BIT (round, shift, saturate, optional ReLU) and buffers it. It streams the
//  results to the feature write-back path over a valid/ready interface, one X_PE-wide
//  beat per 2x2 position. The PE core cannot stall, so this block flags any dropped
//  input instead of applying back-pressure.
// PARAMETERS
//  X_PE         16  output-channel lanes
//  OUT_BIT      24  signed width of each PE result
//  DATA_BIT      8  signed width of each requantized output
//  RESULT_SIZE   2  Winograd output tile side (RESULT_SIZE^2 = NPOS = 4 positions)
//  DEPTH         4  tile entries in the internal FIFO (power of 2)
// PORTS
//  clk            in   1                        clock
//  rst_n          in   1                        synchronous reset, active-low
//  in_valid       in   1                        result beat present (PE core out_valid)
//  poolop         in   1                        1: take result_pool; 0: take result_unpool
//  result_unpool  in   OUT_BIT*NPOS*X_PE        lane i, pos p at [(i*NPOS+p)*OUT_BIT +: OUT_BIT]
//  result_pool    in   OUT_BIT*X_PE             lane i at [i*OUT_BIT +: OUT_BIT]
//  shift          in   5                        right-shift amount; values >23 clamp to 23
//  relu_en        in   1                        1: negative results become 0
//  out_ready      in   1                        downstream accepts beat
//  out_valid      out  1                        beat valid
//  out_data       out  DATA_BIT*X_PE            lane i at [i*DATA_BIT +: DATA_BIT]
//  out_last       out  1                        final beat of a tile
//  overflow       out  1                        sticky: an input beat was dropped
//  busy           out  1                        FIFO non-empty or a stage-1 entry pending
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out_data=0, overflow=0, busy=0; FIFO pointers,
//    count and beat counter cleared; any in-flight data discarded.
//  - Stage 1, cycle t (in_valid=1): register poolop, and for each lane and position
//    compute q = sat(relu((x + rnd) >>> s)). s = min(shift,23); rnd = 1<<(s-1), or 0 if s=0.
//    Do the add in OUT_BIT+1 bits. Saturate to [-2^(DATA_BIT-1), 2^(DATA_BIT-1)-1].
//    With relu_en, q<0 becomes 0. In pool mode only position 0 is used.
//  - Stage 2, cycle t+1: entry {mode, NPOS*X_PE bytes} is written to the FIFO.
//    Earliest out_valid is t+2.
//  - Write acceptance: accept if count<DEPTH, or if count==DEPTH and the head entry
//    retires this same cycle. Otherwise drop the entry, set overflow=1 (cleared only by
//    reset), and leave FIFO contents unchanged.
//  - Output FSM: IDLE -> EMIT when FIFO non-empty. In EMIT, beat counter b drives
//    out_data = pos b of every lane. A beat retires on out_valid&&out_ready.
//    * Unpool entry: beats b=0..3; out_last=1 on b=3.
//    * Pool entry: single beat b=0; out_last=1.
//    * On last-beat handshake: pop, b=0; stay in EMIT if another entry remains, else IDLE.
//  - out_valid/out_data/out_last hold stable while out_valid&&!out_ready (AXI-S rule).
//  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
//  - shift/relu_en/poolop are sampled only at in_valid; changing them mid-stream does
//    not affect buffered entries.
// STRUCTURE
//  - Shared package pe_pkg: NPOS=RESULT_SIZE*RESULT_SIZE, SHIFT_MAX=23,
//    typedef q_t (signed DATA_BIT), and an entry struct {mode, q_t[NPOS][X_PE]}.
//  - One sub-module: requant_lane (single-value round/shift/sat/relu, combinational),
//    instantiated X_PE*NPOS times. FIFO is inline register array plus pointers.
// TESTING
//  1 unpool, shift=4, relu=0, ready=1: lane0 pos0..3 = {40,-40,2047,-3000}
//    -> beats 0..3, lane0 bytes {3,-2,127,-128}; out_last on beat 3; first valid at t+2.
//  2 pool, shift=0, relu=1: lane5=-7, lane6=100 -> 1 beat, bytes {0,100}, out_last=1.
//  3 ready=0, 5 unpool beats -> 4 stored, 5th dropped, overflow=1. Then ready=1 -> exactly
//    16 beats, 4 out_last pulses, busy falls after last.
//  4 FIFO full, in_valid on same cycle as head's last-beat handshake -> entry accepted,
//    overflow stays 0, count stays DEPTH.
//  5 random ready toggling -> out_data/out_last stable while stalled; order matches
//    reference model.
//  6 rst_n=0 mid-tile (beat 2 of 4) -> next cycle out_valid=0, busy=0; no stale beats
//    after reset release.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE output requantization stage.
package pe_pkg;

  localparam int X_PE        = 16;
  localparam int OUT_BIT     = 24;
  localparam int DATA_BIT    = 8;
  localparam int RESULT_SIZE = 2;
  localparam int DEPTH       = 4;
  localparam int NPOS        = RESULT_SIZE * RESULT_SIZE;
  localparam int SHIFT_MAX   = 23;

  // One requantized output value
  typedef logic signed [DATA_BIT-1:0] q_t;

  // One buffered tile: mode=1 means pooled (only position 0 is meaningful)
  typedef struct packed {
    logic                          mode;
    q_t [NPOS-1:0][X_PE-1:0]       q;
  } entry_t;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } out_state_t;

  // Shift amounts beyond the PE result width make no sense; pin them to the top
  function automatic logic [4:0] clamp_shift(input logic [4:0] shift);
    return (shift > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-value requantizer: round-half-up, arithmetic right shift, optional
// ReLU, and saturation of an OUT_BIT signed PE result down to DATA_BIT.
module requant_lane
  import pe_pkg::*;
(
  input  logic signed [OUT_BIT-1:0] x,
  input  logic        [4:0]         shift,
  input  logic                      relu_en,
  output q_t                        q
);

  // One extra bit so adding the rounding constant can never wrap
  localparam int ADD_W = OUT_BIT + 1;
  localparam logic signed [ADD_W-1:0] Q_MAX = ADD_W'((1 << (DATA_BIT - 1)) - 1);
  localparam logic signed [ADD_W-1:0] Q_MIN = ~Q_MAX;

  logic        [4:0]       s;
  logic signed [ADD_W-1:0] rnd;
  logic signed [ADD_W-1:0] sum;
  logic signed [ADD_W-1:0] shifted;

  // Round, shift, then clip into the output range (ReLU folds into the low clip)
  always_comb begin
    s   = clamp_shift(shift);
    rnd = '0;
    if (s != 5'd0) rnd = ADD_W'(1) << (s - 5'd1);
    sum     = {x[OUT_BIT-1], x} + rnd;
    shifted = sum >>> s;
    q       = shifted[DATA_BIT-1:0];
    if (relu_en && shifted[ADD_W-1]) q = '0;
    else if (shifted > Q_MAX)        q = Q_MAX[DATA_BIT-1:0];
    else if (shifted < Q_MIN)        q = Q_MIN[DATA_BIT-1:0];
  end

endmodule

// File: rtl/pe_out_requant.sv
// Output stage behind the Winograd PE core: requantizes each result beat,
// buffers whole tiles in a small FIFO and streams them out one 2x2 position
// per beat. The PE core cannot stall, so a full FIFO drops the tile and
// raises a sticky overflow flag instead of pushing back.
module pe_out_requant
  import pe_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic                            poolop,
  input  logic [OUT_BIT*NPOS*X_PE-1:0]    result_unpool,
  input  logic [OUT_BIT*X_PE-1:0]         result_pool,
  input  logic [4:0]                      shift,
  input  logic                            relu_en,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_BIT*X_PE-1:0]        out_data,
  output logic                            out_last,
  output logic                            overflow,
  output logic                            busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(NPOS);

  q_t               lane_q [NPOS][X_PE];
  logic             s1_valid;
  entry_t           s1_entry;
  entry_t           fifo_mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [BEAT_W-1:0] beat;
  out_state_t       state;
  logic             last_beat;
  logic             beat_fire;
  logic             pop;
  logic             push;
  logic             drop;

  // In pool mode only position 0 carries data; the others are forced to zero
  for (genvar i = 0; i < X_PE; i++) begin : g_lane
    for (genvar p = 0; p < NPOS; p++) begin : g_pos
      logic signed [OUT_BIT-1:0] x;
      if (p == 0) begin : g_p0
        assign x = poolop ? result_pool[i*OUT_BIT +: OUT_BIT]
                          : result_unpool[(i*NPOS+p)*OUT_BIT +: OUT_BIT];
      end else begin : g_pn
        assign x = poolop ? '0 : result_unpool[(i*NPOS+p)*OUT_BIT +: OUT_BIT];
      end
      requant_lane u_requant (
        .x       (x),
        .shift   (shift),
        .relu_en (relu_en),
        .q       (lane_q[p][i])
      );
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (state == S_EMIT);
  assign last_beat = head.mode || (beat == BEAT_W'(NPOS - 1));
  assign beat_fire = out_valid && out_ready;
  assign pop       = beat_fire && last_beat;
  assign push      = s1_valid && ((count < CNT_W'(DEPTH)) || pop);
  assign drop      = s1_valid && !push;
  assign out_data  = out_valid ? head.q[beat] : '0;
  assign out_last  = out_valid && last_beat;
  assign busy      = s1_valid || (count != '0);

  // Stage 1: capture the requantized tile and its mode when the PE presents it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_entry.mode <= poolop;
        for (int p = 0; p < NPOS; p++) begin
          for (int i = 0; i < X_PE; i++) begin
            s1_entry.q[p][i] <= lane_q[p][i];
          end
        end
      end
    end
  end

  // Stage 2: tile storage; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s1_entry;
  end

  // Occupancy after this cycle's push/pop pair
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
  end

  // FIFO bookkeeping, overflow flag and the beat-emitting FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      beat     <= '0;
      state    <= S_IDLE;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          beat <= '0;
          if (push) state <= S_EMIT;
        end
        S_EMIT: begin
          if (beat_fire) begin
            if (last_beat) begin
              beat <= '0;
              if (count_next == '0) state <= S_IDLE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_out_requant.sv
// Self-checking bench for pe_out_requant. Expected beats come from a
// plain-arithmetic requantization model and a queue of pending beats.
module tb_pe_out_requant;
  import pe_pkg::*;

  localparam int UW = OUT_BIT * NPOS * X_PE;
  localparam int PW = OUT_BIT * X_PE;
  localparam int DW = DATA_BIT * X_PE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          poolop = 1'b0;
  logic [UW-1:0] result_unpool = '0;
  logic [PW-1:0] result_pool = '0;
  logic [4:0]    shift = 5'd0;
  logic          relu_en = 1'b0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          overflow;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];

  pe_out_requant dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .poolop        (poolop),
    .result_unpool (result_unpool),
    .result_pool   (result_pool),
    .shift         (shift),
    .relu_en       (relu_en),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Absolute time limit so a wedged design still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference requantization: round half up, floor shift, relu, clip to int8
  function automatic logic [DATA_BIT-1:0] ref_q(input logic [OUT_BIT-1:0] x, input int sh, input bit relu);
    longint v;
    int     s;
    s = (sh > 23) ? 23 : sh;
    v = longint'($signed(x));
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[DATA_BIT-1:0];
  endfunction

  task automatic randomize_results();
    logic [OUT_BIT-1:0] r;
    for (int k = 0; k < X_PE * NPOS; k++) begin
      r = OUT_BIT'($urandom);
      result_unpool[k*OUT_BIT +: OUT_BIT] = OUT_BIT'($signed(r) >>> $urandom_range(0, OUT_BIT - 2));
    end
    for (int k = 0; k < X_PE; k++) begin
      r = OUT_BIT'($urandom);
      result_pool[k*OUT_BIT +: OUT_BIT] = OUT_BIT'($signed(r) >>> $urandom_range(0, OUT_BIT - 2));
    end
  endtask

  // Present one PE beat; if it is expected to be stored, queue its output beats
  task automatic load_beat(input bit pool, input logic [4:0] sh, input bit relu, input bit model);
    beat_t b;
    in_valid = 1'b1;
    poolop   = pool;
    shift    = sh;
    relu_en  = relu;
    if (model) begin
      if (pool) begin
        for (int i = 0; i < X_PE; i++)
          b.data[i*DATA_BIT +: DATA_BIT] = ref_q(result_pool[i*OUT_BIT +: OUT_BIT], int'(sh), relu);
        b.last = 1'b1;
        exp_q.push_back(b);
      end else begin
        for (int p = 0; p < NPOS; p++) begin
          for (int i = 0; i < X_PE; i++)
            b.data[i*DATA_BIT +: DATA_BIT] = ref_q(result_unpool[(i*NPOS+p)*OUT_BIT +: OUT_BIT], int'(sh), relu);
          b.last = (p == NPOS - 1);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_unpool();
    logic [7:0] want_l0 [4];
    beat_t e;
    want_l0 = '{8'd3, 8'hFE, 8'd127, 8'h80};
    out_ready = 1'b1;
    randomize_results();
    result_unpool[0*OUT_BIT +: OUT_BIT] = OUT_BIT'(40);
    result_unpool[1*OUT_BIT +: OUT_BIT] = OUT_BIT'(-40);
    result_unpool[2*OUT_BIT +: OUT_BIT] = OUT_BIT'(2047);
    result_unpool[3*OUT_BIT +: OUT_BIT] = OUT_BIT'(-3000);
    load_beat(1'b0, 5'd4, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL unpool_latency_t1 got %b want 0", out_valid); end
    @(negedge clk);
    for (int p = 0; p < NPOS; p++) begin
      if (p > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL unpool_valid beat %0d got %b want 1", p, out_valid); end
      checks++; if (out_data[7:0] !== want_l0[p]) begin errors++; $display("[TB] FAIL unpool_lane0 beat %0d got %0d want %0d", p, $signed(out_data[7:0]), $signed(want_l0[p])); end
      checks++; if (out_data !== e.data) begin errors++; $display("[TB] FAIL unpool_data beat %0d got %h want %h", p, out_data, e.data); end
      checks++; if (out_last !== (p == NPOS - 1)) begin errors++; $display("[TB] FAIL unpool_last beat %0d got %b want %b", p, out_last, (p == NPOS - 1)); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL unpool_done_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL unpool_done_busy got %b want 0", busy); end
  endtask

  task automatic test_pool();
    beat_t e;
    out_ready = 1'b1;
    randomize_results();
    result_pool[5*OUT_BIT +: OUT_BIT] = OUT_BIT'(-7);
    result_pool[6*OUT_BIT +: OUT_BIT] = OUT_BIT'(100);
    load_beat(1'b1, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pool_valid got %b want 1", out_valid); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("[TB] FAIL pool_last got %b want 1", out_last); end
    checks++; if (out_data[5*8 +: 8] !== 8'd0) begin errors++; $display("[TB] FAIL pool_lane5 got %0d want 0", $signed(out_data[5*8 +: 8])); end
    checks++; if (out_data[6*8 +: 8] !== 8'd100) begin errors++; $display("[TB] FAIL pool_lane6 got %0d want 100", $signed(out_data[6*8 +: 8])); end
    checks++; if (out_data !== e.data) begin errors++; $display("[TB] FAIL pool_data got %h want %h", out_data, e.data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pool_single_beat got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    beat_t e;
    int beats = 0;
    int lasts = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      randomize_results();
      load_beat(1'b0, 5'($urandom_range(0, 31)), 1'($urandom), k < 4);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovf_busy got %b want 1", busy); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && beats < 16; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL ovf_extra_beat got beat want none");
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.data) begin errors++; $display("[TB] FAIL ovf_data beat %0d got %h want %h", beats, out_data, e.data); end
          checks++; if (out_last !== e.last) begin errors++; $display("[TB] FAIL ovf_last beat %0d got %b want %b", beats, out_last, e.last); end
        end
        beats++;
        if (out_last) lasts++;
      end
      @(negedge clk);
    end
    checks++; if (beats !== 16) begin errors++; $display("[TB] FAIL ovf_beat_count got %0d want 16", beats); end
    checks++; if (lasts !== 4) begin errors++; $display("[TB] FAIL ovf_last_count got %0d want 4", lasts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_busy_after got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_no_extra got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_reset_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_simultaneous();
    beat_t e;
    int beats = 0;
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      randomize_results();
      load_beat(1'b0, 5'($urandom_range(0, 31)), 1'($urandom), 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int p = 0; p < NPOS; p++) begin
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== e.data || out_last !== e.last) begin
        errors++; $display("[TB] FAIL full_head beat %0d got v=%b l=%b %h want v=1 l=%b %h", p, out_valid, out_last, out_data, e.last, e.data);
      end
      if (p == 2) begin
        randomize_results();
        load_beat(1'b0, 5'($urandom_range(0, 31)), 1'($urandom), 1'b1);
      end
      if (p == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_simul_no_ovf got %b want 0", overflow); end
    randomize_results();
    load_beat(1'b0, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_count_depth got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && beats < 16; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL full_extra_beat got beat want none");
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.data || out_last !== e.last) begin
            errors++; $display("[TB] FAIL full_drain beat %0d got l=%b %h want l=%b %h", beats, out_last, out_data, e.last, e.data);
          end
        end
        beats++;
      end
      @(negedge clk);
    end
    checks++; if (beats !== 16) begin errors++; $display("[TB] FAIL full_drain_count got %0d want 16", beats); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_after got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_random_stall();
    localparam int N_ENT = 24;
    beat_t         e;
    int            sent = 0;
    int            done_entries = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    for (int cyc = 0; cyc < 4000 && done_entries < N_ENT; cyc++) begin
      out_ready = 1'($urandom);
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++; $display("[TB] FAIL stall_hold got v=%b l=%b %h want v=1 l=%b %h", out_valid, out_last, out_data, prev_last, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL rand_extra_beat got beat want none");
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.data || out_last !== e.last) begin
            errors++; $display("[TB] FAIL rand_order got l=%b %h want l=%b %h", out_last, out_data, e.last, e.data);
          end
          if (e.last) done_entries++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      randomize_results();
      in_valid = 1'b0;
      shift    = 5'($urandom_range(0, 31));
      relu_en  = 1'($urandom);
      poolop   = 1'($urandom);
      if (sent < N_ENT && (sent - done_entries) < DEPTH && $urandom_range(0, 2) != 0) begin
        load_beat(1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 1'b1);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (done_entries !== N_ENT) begin errors++; $display("[TB] FAIL rand_complete got %0d want %0d", done_entries, N_ENT); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL rand_leftover got %0d want 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rand_busy_after got %b want 0", busy); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b1;
    randomize_results();
    load_beat(1'b0, 5'd4, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_beat2 got v=%b l=%b want v=1 l=0", out_valid, out_last); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL rstmid_data got %h want 0", out_data); end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL rstmid_stale got %0d want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_unpool();
    test_pool();
    test_overflow();
    test_full_simultaneous();
    test_random_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
